// File: rtl/router_pkg.sv
// Derived-constant helpers shared by the router and its upstream feeders
// (ofm_packer), plus the packer's pending-slot state type.
package router_pkg;

  typedef enum logic [0:0] {
    PEND_EMPTY = 1'b0,
    PEND_HELD  = 1'b1
  } pend_state_e;

  function automatic int calc_num_cycle(input int bottleneck, input int ou, input int delta_x);
    return (bottleneck * ou) / delta_x;
  endfunction

  function automatic int calc_data_amount(input int k, input int out_ch);
    return k * out_ch;
  endfunction

  function automatic int calc_how_many_pixel(input int data_amount, input int num_cycle);
    return (data_amount + num_cycle - 1) / num_cycle;
  endfunction

  function automatic int calc_wire_num(input int how_many_pixel, input int bit_ofm);
    return how_many_pixel * bit_ofm;
  endfunction

  function automatic int calc_words_per_tile(input int data_amount, input int how_many_pixel);
    return (data_amount + how_many_pixel - 1) / how_many_pixel;
  endfunction

  function automatic int calc_pace(input int num_cycle, input int words_per_tile);
    int p;
    p = num_cycle / words_per_tile;
    if (p < 1) begin
      p = 1;
    end
    return p;
  endfunction

  // Bits needed for a counter over 0..n_values-1, never less than one.
  function automatic int calc_cnt_width(input int n_values);
    int w;
    w = $clog2(n_values);
    if (w < 1) begin
      w = 1;
    end
    return w;
  endfunction

endpackage

// File: rtl/ofm_pace_timer.sv
// Write pacing counter: loads PACE-1 on every write and counts down to zero;
// the next write is only allowed once it is back at zero.
module ofm_pace_timer
  import router_pkg::*;
#(
  parameter int PACE = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic load,
  output logic pace_ok
);

  localparam int CW = calc_cnt_width(PACE);

  logic [CW-1:0] cnt_r;

  // Pace countdown register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_r <= '0;
    end else if (load) begin
      cnt_r <= CW'(PACE - 1);
    end else if (cnt_r != '0) begin
      cnt_r <= cnt_r - CW'(1);
    end
  end

  assign pace_ok = (cnt_r == '0);

endmodule

// File: rtl/ofm_packer.sv
// Packs H OFM pixels per word and feeds one router branch input (WRITE/full).
// Optional write pacing to the bottleneck budget under `define PACKER_PACE_EN.
module ofm_packer
  import router_pkg::*;
#(
  parameter  int K           = 3,
  parameter  int BOTTLENECK  = 1668,
  parameter  int BIT_OFM     = 29,
  parameter  int DELTA_X     = 16,
  parameter  int OU          = 8,
  parameter  int OUT_CH      = 64,
  localparam int NUM_CYCLE   = calc_num_cycle(BOTTLENECK, OU, DELTA_X),
  localparam int DATA_AMOUNT = calc_data_amount(K, OUT_CH),
  localparam int H           = calc_how_many_pixel(DATA_AMOUNT, NUM_CYCLE),
  localparam int WIRE_NUM    = calc_wire_num(H, BIT_OFM)
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [BIT_OFM-1:0]  PIXEL_IN,
  input  logic                PIXEL_VALID,
  output logic                pixel_ready,
  input  logic                DOWNSTREAM_FULL,
  output logic [WIRE_NUM-1:0] packed_data,
  output logic                packed_write,
  output logic                tile_done
);

  localparam int LANE_W = calc_cnt_width(H);
  localparam int PIX_W  = calc_cnt_width(DATA_AMOUNT);

  logic [LANE_W-1:0]   lane_cnt_r;
  logic [PIX_W-1:0]    pix_cnt_r;
  logic [WIRE_NUM-1:0] asm_r;
  logic [WIRE_NUM-1:0] pend_data_r;
  logic                pend_last_r;
  pend_state_e         state_r;
  pend_state_e         state_next_s;

  logic [WIRE_NUM-1:0] word_s;
  logic                pend_valid_s;
  logic                last_pix_s;
  logic                lane_room_s;
  logic                ready_s;
  logic                accept_s;
  logic                close_s;
  logic                pace_ok_s;
  logic                write_s;

  assign pend_valid_s = (state_r == PEND_HELD);
  assign last_pix_s   = (pix_cnt_r == PIX_W'(DATA_AMOUNT - 1));
  // lane_cnt never exceeds H-1, so "not the top lane" is the same as "< H-1".
  assign lane_room_s  = (lane_cnt_r != LANE_W'(H - 1));
  assign ready_s      = !pend_valid_s || (lane_room_s && !last_pix_s);
  assign accept_s     = PIXEL_VALID && ready_s;
  assign close_s      = accept_s && (!lane_room_s || last_pix_s);
  assign write_s      = pend_valid_s && !DOWNSTREAM_FULL && pace_ok_s;

  // Current assembly word with the incoming pixel dropped into its lane
  always_comb begin
    word_s = asm_r;
    for (int i = 0; i < H; i++) begin
      if (lane_cnt_r == LANE_W'(i)) begin
        word_s[i*BIT_OFM +: BIT_OFM] = PIXEL_IN;
      end else begin
        word_s[i*BIT_OFM +: BIT_OFM] = asm_r[i*BIT_OFM +: BIT_OFM];
      end
    end
  end

  // Assembly register, lane counter and tile pixel counter
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      asm_r      <= '0;
      lane_cnt_r <= '0;
      pix_cnt_r  <= '0;
    end else if (accept_s) begin
      pix_cnt_r <= last_pix_s ? '0 : pix_cnt_r + PIX_W'(1);
      if (close_s) begin
        asm_r      <= '0;
        lane_cnt_r <= '0;
      end else begin
        asm_r      <= word_s;
        lane_cnt_r <= lane_cnt_r + LANE_W'(1);
      end
    end
  end

  // Pending word register, loaded only on word close (slot is always empty then)
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pend_data_r <= '0;
      pend_last_r <= 1'b0;
    end else if (close_s) begin
      pend_data_r <= word_s;
      pend_last_r <= last_pix_s;
    end
  end

  // Pending slot state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= PEND_EMPTY;
    end else begin
      state_r <= state_next_s;
    end
  end

  // Pending slot next-state logic
  always_comb begin
    state_next_s = state_r;
    case (state_r)
      PEND_EMPTY: begin
        if (close_s) begin
          state_next_s = PEND_HELD;
        end else begin
          state_next_s = PEND_EMPTY;
        end
      end
      PEND_HELD: begin
        if (write_s) begin
          state_next_s = PEND_EMPTY;
        end else begin
          state_next_s = PEND_HELD;
        end
      end
      default: state_next_s = PEND_EMPTY;
    endcase
  end

`ifdef PACKER_PACE_EN
  localparam int WORDS_PER_TILE = calc_words_per_tile(DATA_AMOUNT, H);
  localparam int PACE           = calc_pace(NUM_CYCLE, WORDS_PER_TILE);

  ofm_pace_timer #(
    .PACE(PACE)
  ) u_pace_timer (
    .clk    (clk),
    .rst_n  (rst_n),
    .load   (write_s),
    .pace_ok(pace_ok_s)
  );
`else
  assign pace_ok_s = 1'b1;
`endif

  assign pixel_ready  = ready_s;
  assign packed_data  = pend_data_r;
  assign packed_write = write_s;
  assign tile_done    = write_s && pend_last_r;

endmodule

// File: tb/tb_ofm_packer.sv
// Bench for ofm_packer: three instances (H=1, H=2, H=4) against a queue-based
// word scoreboard built from the pixel-grouping rules.
module tb_ofm_packer;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic [28:0] pix [3];
  logic        val [3];
  logic        full [3];

  wire         rdy0, rdy1, rdy2;
  wire         wr0, wr1, wr2;
  wire         td0, td1, td2;
  wire [28:0]  pd0;
  wire [57:0]  pd1;
  wire [115:0] pd2;

  always #5 clk = ~clk;

  ofm_packer u_h1 (
    .clk(clk), .rst_n(rst_n), .PIXEL_IN(pix[0]), .PIXEL_VALID(val[0]),
    .pixel_ready(rdy0), .DOWNSTREAM_FULL(full[0]), .packed_data(pd0),
    .packed_write(wr0), .tile_done(td0));

  ofm_packer #(.BOTTLENECK(192)) u_h2 (
    .clk(clk), .rst_n(rst_n), .PIXEL_IN(pix[1]), .PIXEL_VALID(val[1]),
    .pixel_ready(rdy1), .DOWNSTREAM_FULL(full[1]), .packed_data(pd1),
    .packed_write(wr1), .tile_done(td1));

  ofm_packer #(.BOTTLENECK(96)) u_h4 (
    .clk(clk), .rst_n(rst_n), .PIXEL_IN(pix[2]), .PIXEL_VALID(val[2]),
    .pixel_ready(rdy2), .DOWNSTREAM_FULL(full[2]), .packed_data(pd2),
    .packed_write(wr2), .tile_done(td2));

  int           tests = 0;
  int           fails = 0;
  int           cycle_n = 0;
  int           hh [3];
  int           space_exp;
  logic [116:0] expq [3][$];
  logic [115:0] asm_m [3];
  int           lanes_m [3];
  int           pidx_m [3];
  int           nwr [3];
  int           ntd [3];
  logic         acc [3];
  logic [115:0] lastpd [3];
  logic         lasttd [3];
  logic [115:0] td_data0;
  int           last_wr0;
  bit           spacing_on;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic reset_model();
    for (int i = 0; i < 3; i++) begin
      expq[i].delete();
      asm_m[i]   = '0;
      lanes_m[i] = 0;
      pidx_m[i]  = 0;
    end
  endtask

  // Checks writes against the scoreboard, then folds accepted pixels into the model.
  task automatic sample();
    logic [115:0] pdv [3];
    logic         wrv [3];
    logic         tdv [3];
    logic         rdv [3];
    logic [116:0] e;
    pdv[0] = {87'd0, pd0}; pdv[1] = {58'd0, pd1}; pdv[2] = pd2;
    wrv[0] = wr0; wrv[1] = wr1; wrv[2] = wr2;
    tdv[0] = td0; tdv[1] = td1; tdv[2] = td2;
    rdv[0] = rdy0; rdv[1] = rdy1; rdv[2] = rdy2;
    for (int i = 0; i < 3; i++) begin
      acc[i] = val[i] && rdv[i];
      if (wrv[i]) begin
        chk($sformatf("write_has_word_%0d", i), 128'(expq[i].size() > 0), 128'(1));
        if (expq[i].size() > 0) begin
          e = expq[i].pop_front();
          chk($sformatf("word_data_%0d", i), 128'(pdv[i]), 128'(e[115:0]));
          chk($sformatf("word_tile_done_%0d", i), 128'(tdv[i]), 128'(e[116]));
        end
        nwr[i]++;
        if (tdv[i]) ntd[i]++;
        lastpd[i] = pdv[i];
        lasttd[i] = tdv[i];
        if (i == 0) begin
          if (tdv[i]) td_data0 = pdv[0];
          if (spacing_on && last_wr0 >= 0) chk("write_spacing", 128'(cycle_n - last_wr0), 128'(space_exp));
          last_wr0 = cycle_n;
        end
      end else if (tdv[i]) begin
        chk($sformatf("tile_done_without_write_%0d", i), 128'(tdv[i]), 128'(0));
      end
      if (acc[i]) begin
        asm_m[i] = asm_m[i] | (116'(pix[i]) << (lanes_m[i] * 29));
        lanes_m[i]++;
        if (lanes_m[i] == hh[i] || pidx_m[i] == 191) begin
          expq[i].push_back({pidx_m[i] == 191, asm_m[i]});
          asm_m[i]   = '0;
          lanes_m[i] = 0;
        end
        pidx_m[i] = (pidx_m[i] == 191) ? 0 : pidx_m[i] + 1;
      end
    end
  endtask

  task automatic cyc();
    @(negedge clk);
    sample();
    @(posedge clk);
    #1;
    cycle_n++;
  endtask

  task automatic drain(input int n);
    for (int i = 0; i < 3; i++) begin
      val[i]  = 1'b0;
      full[i] = 1'b0;
    end
    repeat (n) cyc();
  endtask

  initial begin
    int           bn [3];
    int           nc, wpt, pace;
    int           n0, td0b, k, cnt2, got;
    logic [28:0]  p;
    logic [28:0]  pv [4];
    logic [115:0] exp_w;

    bn[0] = 1668; bn[1] = 192; bn[2] = 96;
    for (int i = 0; i < 3; i++) begin
      nc    = bn[i] * 8 / 16;
      hh[i] = (192 + nc - 1) / nc;
    end
    space_exp = 2;
`ifdef PACKER_PACE_EN
    nc   = 1668 * 8 / 16;
    wpt  = (192 + hh[0] - 1) / hh[0];
    pace = nc / wpt;
    if (pace < 1) pace = 1;
    if (pace > 2) space_exp = pace;
`endif
    for (int i = 0; i < 3; i++) begin
      pix[i] = 29'd0; val[i] = 1'b0; full[i] = 1'b0;
      nwr[i] = 0; ntd[i] = 0; acc[i] = 1'b0; lastpd[i] = '0; lasttd[i] = 1'b0;
    end
    reset_model();
    last_wr0 = -1; spacing_on = 1'b0; td_data0 = '0;

    // Reset state
    #1 rst_n = 1'b0;
    #1;
    chk("rst_ready_h1", 128'(rdy0), 128'(1));
    chk("rst_data_h1", 128'(pd0), 128'(0));
    chk("rst_write_h1", 128'(wr0), 128'(0));
    chk("rst_tile_done_h1", 128'(td0), 128'(0));
    chk("rst_ready_h4", 128'(rdy2), 128'(1));
    chk("rst_data_h4", 128'(pd2), 128'(0));
    @(posedge clk); #1;
    rst_n = 1'b1;
    cyc(); cyc();

    // H=1 tile: pixels 1..192 streamed with valid held high
    spacing_on = 1'b1; last_wr0 = -1;
    n0 = nwr[0]; td0b = ntd[0];
    k = 1; pix[0] = 29'd1; val[0] = 1'b1;
    for (int c = 0; c < 1200 && (nwr[0] - n0) < 192; c++) begin
      cyc();
      if (acc[0]) begin
        if (k == 192) val[0] = 1'b0;
        else begin
          k++;
          pix[0] = 29'(k);
        end
      end
    end
    spacing_on = 1'b0;
    drain(4);
    chk("h1_tile_writes", 128'(nwr[0] - n0), 128'(192));
    chk("h1_tile_done_count", 128'(ntd[0] - td0b), 128'(1));
    chk("h1_tile_done_data", 128'(td_data0), 128'(192));

    // Downstream full held for 20 cycles after a word closes
    p = 29'($urandom);
    full[0] = 1'b1; val[0] = 1'b1; pix[0] = p; got = 0;
    for (int c = 0; c < 10 && got == 0; c++) begin
      cyc();
      if (acc[0]) got = 1;
    end
    val[0] = 1'b0;
    chk("full_pixel_accepted", 128'(got), 128'(1));
    n0 = nwr[0];
    repeat (20) begin
      cyc();
      chk("full_hold_no_write", 128'(wr0), 128'(0));
      chk("full_hold_data", 128'(pd0), 128'(p));
      chk("full_hold_ready", 128'(rdy0), 128'(0));
    end
    full[0] = 1'b0;
    cyc();
    chk("release_single_write", 128'(nwr[0] - n0), 128'(1));
    chk("release_data", 128'(lastpd[0]), 128'(p));
    val[0] = 1'b1; pix[0] = 29'($urandom); got = 0;
    for (int c = 0; c < 40 && got < 3; c++) begin
      cyc();
      if (acc[0]) begin
        got++;
        pix[0] = 29'($urandom);
      end
    end
    drain(20);
    chk("after_release_flow", 128'(nwr[0] - n0), 128'(4));

    // H=2: two pixels form one word, first pixel at the LSBs
    val[1] = 1'b1; pix[1] = 29'h1; got = 0;
    for (int c = 0; c < 10 && got < 2; c++) begin
      cyc();
      if (acc[1]) begin
        got++;
        pix[1] = 29'h2;
      end
    end
    val[1] = 1'b0;
    n0 = nwr[1];
    for (int c = 0; c < 10 && nwr[1] == n0; c++) cyc();
    exp_w = '0; exp_w[57:29] = 29'h2; exp_w[28:0] = 29'h1;
    chk("h2_word", 128'(lastpd[1]), 128'(exp_w));

    // Random traffic; H=4 instance gets exactly one 192-pixel tile
    n0 = nwr[2]; td0b = ntd[2]; cnt2 = 0;
    for (int c = 0; c < 3000 && cnt2 < 192; c++) begin
      for (int i = 0; i < 3; i++) begin
        pix[i]  = 29'($urandom);
        full[i] = ($urandom_range(0, 3) == 0);
        val[i]  = ($urandom_range(0, 3) != 0);
      end
      cyc();
      if (acc[2]) cnt2++;
    end
    drain(40);
    chk("h4_pixels", 128'(cnt2), 128'(192));
    chk("h4_tile_writes", 128'(nwr[2] - n0), 128'(48));
    chk("h4_tile_done_count", 128'(ntd[2] - td0b), 128'(1));
    chk("h4_tile_done_on_last", 128'(lasttd[2]), 128'(1));
    for (int i = 0; i < 3; i++) chk($sformatf("drained_%0d", i), 128'(expq[i].size()), 128'(0));

    // Reset with two of four lanes filled
    val[2] = 1'b1; pix[2] = 29'($urandom); got = 0;
    for (int c = 0; c < 10 && got < 2; c++) begin
      cyc();
      if (acc[2]) begin
        got++;
        pix[2] = 29'($urandom);
      end
    end
    val[2] = 1'b0;
    rst_n = 1'b0;
    #1;
    chk("midrst_ready", 128'(rdy2), 128'(1));
    chk("midrst_data_h4", 128'(pd2), 128'(0));
    chk("midrst_write", 128'(wr2), 128'(0));
    chk("midrst_tile_done", 128'(td2), 128'(0));
    chk("midrst_data_h1", 128'(pd0), 128'(0));
    chk("midrst_data_h2", 128'(pd1), 128'(0));
    reset_model();
    #2 rst_n = 1'b1;
    n0 = nwr[2];
    repeat (4) cyc();
    chk("no_write_after_reset", 128'(nwr[2] - n0), 128'(0));
    for (int j = 0; j < 4; j++) pv[j] = 29'($urandom);
    val[2] = 1'b1; pix[2] = pv[0]; got = 0;
    for (int c = 0; c < 20 && got < 4; c++) begin
      cyc();
      if (acc[2]) begin
        got++;
        if (got < 4) pix[2] = pv[got];
      end
    end
    drain(10);
    exp_w = {pv[3], pv[2], pv[1], pv[0]};
    chk("post_reset_writes", 128'(nwr[2] - n0), 128'(1));
    chk("post_reset_word", 128'(lastpd[2]), 128'(exp_w));

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
